// File: rtl/hilo_pkg.sv
// Shared HI/LO definitions: op encodings, sequencer states and default width.
// Also used by the decoder and the write-back mux select logic.
package hilo_pkg;

  localparam int unsigned HILO_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic logic op_is_iter(input op_e op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide, one bit per step.
// After WIDTH steps hi_part holds product-high / remainder, lo_part holds product-low / quotient.
module muldiv_iter_core
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = HILO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             load_div,
  input  logic [WIDTH-1:0] load_a,
  input  logic [WIDTH-1:0] load_b,
  input  logic             step,
  output logic [WIDTH-1:0] hi_part,
  output logic [WIDTH-1:0] lo_part
);

  logic             is_div;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] opnd;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] shreg_next;

  always_comb begin
    sum        = '0;
    shifted    = {acc, shreg[WIDTH-1]};
    fits       = 1'b0;
    acc_next   = acc;
    shreg_next = shreg;
    if (is_div) begin
      // shifted is the WIDTH+1 bit partial remainder; a fit means quotient bit 1
      fits       = shifted >= {1'b0, opnd};
      acc_next   = fits ? (shifted[WIDTH-1:0] - opnd) : shifted[WIDTH-1:0];
      shreg_next = {shreg[WIDTH-2:0], fits};
    end else begin
      sum        = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : '0);
      acc_next   = sum[WIDTH:1];
      shreg_next = {sum[0], shreg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_div <= 1'b0;
      acc    <= '0;
      shreg  <= '0;
      opnd   <= '0;
    end else if (load) begin
      is_div <= load_div;
      acc    <= '0;
      shreg  <= load_div ? load_a : load_b;
      opnd   <= load_div ? load_b : load_a;
    end else if (step) begin
      acc    <= acc_next;
      shreg  <= shreg_next;
    end
  end

  assign hi_part = acc;
  assign lo_part = shreg;

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// HI/LO register owner: sequences iterative mult/div and MTHI/MTLO writes, raises Stall.
// state | meaning
// IDLE  | accepts Start; MTHI/MTLO write directly, mult/div load the core
// RUN   | one core step per cycle, WIDTH cycles
// FIX   | sign fixup, HI/LO written at end of cycle unless aborted
module hilo_muldiv_sequencer
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = HILO_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             HiLoRead,
  input  logic             Abort,
  output logic [WIDTH-1:0] ReadDataHi,
  output logic [WIDTH-1:0] ReadDataLo,
  output logic             Busy,
  output logic             Done,
  output logic             Stall
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e           state, state_next;
  logic [CW-1:0]    cnt;
  logic             is_div_q;
  logic             neg_res_q;
  logic             neg_rem_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;

  op_e              op_in;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  logic             load, step, wr_fix, wr_hi, wr_lo;

  logic [WIDTH-1:0]   core_hi, core_lo;
  logic [2*WIDTH-1:0] prod_full, prod_fixed;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign op_in  = op_e'(Op);
  assign sign_a = op_is_signed(op_in) & OperandA[WIDTH-1];
  assign sign_b = op_is_signed(op_in) & OperandB[WIDTH-1];
  assign mag_a  = sign_a ? -OperandA : OperandA;
  assign mag_b  = sign_b ? -OperandB : OperandB;

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (Clk),
    .rst      (Rst),
    .load     (load),
    .load_div (op_is_div(op_in)),
    .load_a   (mag_a),
    .load_b   (mag_b),
    .step     (step),
    .hi_part  (core_hi),
    .lo_part  (core_lo)
  );

  // Quotient follows sA^sB, remainder follows the dividend.
  assign prod_full  = {core_hi, core_lo};
  assign prod_fixed = neg_res_q ? -prod_full : prod_full;
  assign fix_hi = is_div_q ? (neg_rem_q ? -core_hi : core_hi) : prod_fixed[2*WIDTH-1:WIDTH];
  assign fix_lo = is_div_q ? (neg_res_q ? -core_lo : core_lo) : prod_fixed[WIDTH-1:0];

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    wr_fix     = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (Start && !Abort) begin
          if (op_is_iter(op_in)) begin
            load       = 1'b1;
            state_next = ST_RUN;
          end else begin
            wr_hi = (op_in == OP_MTHI);
            wr_lo = (op_in == OP_MTLO);
          end
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (Abort)          state_next = ST_IDLE;
        else if (cnt == '0) state_next = ST_FIX;
      end
      ST_FIX: begin
        wr_fix     = !Abort;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= wr_fix;
      if (load) begin
        cnt       <= CW'(WIDTH - 1);
        is_div_q  <= op_is_div(op_in);
        neg_res_q <= sign_a ^ sign_b;
        neg_rem_q <= sign_a;
      end else if (step && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (wr_fix) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end else begin
        if (wr_hi) hi_q <= OperandA;
        if (wr_lo) lo_q <= OperandA;
      end
    end
  end

  assign ReadDataHi = hi_q;
  assign ReadDataLo = lo_q;
  assign Busy       = (state != ST_IDLE);
  assign Done       = done_q;
  assign Stall      = Busy & (HiLoRead | Start);

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Directed bench for hilo_muldiv_sequencer: per-cycle comparison against an
// arithmetic reference model, plus hand-computed literal results.
module tb_hilo_muldiv_sequencer;

  localparam int WIDTH = 32;

  logic             Clk, Rst, Start, HiLoRead, Abort;
  logic [2:0]       Op;
  logic [WIDTH-1:0] OperandA, OperandB;
  logic [WIDTH-1:0] ReadDataHi, ReadDataLo;
  logic             Busy, Done, Stall;

  hilo_muldiv_sequencer #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB),
    .HiLoRead(HiLoRead), .Abort(Abort),
    .ReadDataHi(ReadDataHi), .ReadDataLo(ReadDataLo),
    .Busy(Busy), .Done(Done), .Stall(Stall)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic void ref_result(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    lo = '0;
    case (op)
      3'd0: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      3'd2: begin
        if (b == 0) begin
          hi = a;
          lo = (sa < 0) ? 32'd1 : 32'hFFFFFFFF;
        end else begin
          lo = 32'(sa / sb);
          hi = 32'(sa % sb);
        end
      end
      3'd3: begin
        if (b == 0) begin hi = a; lo = 32'hFFFFFFFF; end
        else begin lo = a / b; hi = a % b; end
      end
      default: ;
    endcase
  endfunction

  // Model: busy countdown of WIDTH+1 cycles after acceptance, then commit.
  int          m_left;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_done;

  always @(posedge Clk) begin : model
    int          left_n;
    logic [31:0] hi_n, lo_n, ph, pl;
    logic        done_n;
    left_n = m_left; hi_n = m_hi; lo_n = m_lo; ph = p_hi; pl = p_lo; done_n = 1'b0;
    if (Rst) begin
      left_n = 0; hi_n = '0; lo_n = '0;
    end else if (left_n > 0) begin
      if (Abort) left_n = 0;
      else begin
        left_n--;
        if (left_n == 0) begin hi_n = ph; lo_n = pl; done_n = 1'b1; end
      end
    end else if (Start && !Abort) begin
      if (Op < 3'd4) begin
        ref_result(Op, OperandA, OperandB, ph, pl);
        left_n = WIDTH + 1;
      end else if (Op == 3'd4) hi_n = OperandA;
      else if (Op == 3'd5) lo_n = OperandA;
    end
    m_left <= left_n; m_hi <= hi_n; m_lo <= lo_n;
    p_hi <= ph; p_lo <= pl; m_done <= done_n;
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("hi", 64'(ReadDataHi), 64'(m_hi));
      chk("lo", 64'(ReadDataLo), 64'(m_lo));
      chk("busy", 64'(Busy), 64'(m_left > 0));
      chk("done", 64'(Done), 64'(m_done));
      chk("stall", 64'(Stall), 64'((m_left > 0) && (HiLoRead || Start)));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    tick(1);
    Start = 1'b0; Op = 3'd7;
  endtask

  // Called one cycle after acceptance; lat counts cycles from acceptance cycle t.
  task automatic wait_done(output int lat, output int busy_n);
    bit seen;
    seen = 1'b0; lat = 0; busy_n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge Clk);
      if (Busy) busy_n++;
      if (Done) begin lat = i; seen = 1'b1; break; end
    end
    chk("done_seen", 64'(seen), 64'd1);
    tick(1);
  endtask

  int lat, busy_n, done_cnt;

  initial begin
    Rst = 1'b1; Start = 1'b0; Op = 3'd7; OperandA = '0; OperandB = '0;
    HiLoRead = 1'b0; Abort = 1'b0;
    tick(2);
    Start = 1'b1; Op = 3'd4; OperandA = 32'hABCD;
    tick(1);
    Start = 1'b0; Rst = 1'b0; cmp_en = 1'b1;
    @(negedge Clk);
    chk("reset_hi", 64'(ReadDataHi), 64'd0);
    chk("reset_busy", 64'(Busy), 64'd0);
    tick(1);

    issue(3'd0, 32'hFFFFFFFD, 32'd5);
    wait_done(lat, busy_n);
    chk("t1_latency", 64'(lat), 64'd34);
    chk("t1_hi", 64'(ReadDataHi), 64'hFFFFFFFF);
    chk("t1_lo", 64'(ReadDataLo), 64'hFFFFFFF1);

    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat, busy_n);
    chk("t2_busy_cycles", 64'(busy_n), 64'd33);
    chk("t2_hi", 64'(ReadDataHi), 64'hFFFFFFFE);
    chk("t2_lo", 64'(ReadDataLo), 64'h00000001);

    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_done(lat, busy_n);
    chk("t3_lo", 64'(ReadDataLo), 64'hFFFFFFFD);
    chk("t3_hi", 64'(ReadDataHi), 64'hFFFFFFFF);

    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat, busy_n);
    chk("t4_lo", 64'(ReadDataLo), 64'h80000000);
    chk("t4_hi", 64'(ReadDataHi), 64'h0);

    issue(3'd3, 32'd9, 32'd0);
    wait_done(lat, busy_n);
    chk("t5_lo", 64'(ReadDataLo), 64'hFFFFFFFF);
    chk("t5_hi", 64'(ReadDataHi), 64'd9);

    issue(3'd2, 32'd9, 32'd0);
    wait_done(lat, busy_n);
    chk("div0_lo", 64'(ReadDataLo), 64'hFFFFFFFF);
    chk("div0_hi", 64'(ReadDataHi), 64'd9);

    issue(3'd3, 32'd100, 32'd7);
    wait_done(lat, busy_n);
    chk("divu_lo", 64'(ReadDataLo), 64'd14);
    chk("divu_hi", 64'(ReadDataHi), 64'd2);

    // Stall while in flight; second op re-presented until taken in IDLE.
    issue(3'd0, 32'd7, 32'd6);
    tick(4);
    HiLoRead = 1'b1; Start = 1'b1; Op = 3'd1; OperandA = 32'h10000; OperandB = 32'h10000;
    tick(28);
    @(negedge Clk);
    chk("t6_stall_t33", 64'(Stall), 64'd1);
    tick(1);
    @(negedge Clk);
    chk("t6_stall_t34", 64'(Stall), 64'd0);
    chk("t6_first_lo", 64'(ReadDataLo), 64'd42);
    tick(1);
    Start = 1'b0; HiLoRead = 1'b0; Op = 3'd7;
    wait_done(lat, busy_n);
    chk("t6_second_hi", 64'(ReadDataHi), 64'd1);
    chk("t6_second_lo", 64'(ReadDataLo), 64'd0);

    // Abort during RUN.
    issue(3'd0, 32'd3, 32'd3);
    tick(9);
    Abort = 1'b1;
    tick(1);
    Abort = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done) done_cnt++;
    end
    chk("abort_run_done", 64'(done_cnt), 64'd0);
    chk("abort_run_hi", 64'(ReadDataHi), 64'd1);
    chk("abort_run_lo", 64'(ReadDataLo), 64'd0);
    tick(1);

    issue(3'd5, 32'h1234, 32'd0);
    @(negedge Clk);
    chk("mtlo_lo", 64'(ReadDataLo), 64'h1234);
    chk("mtlo_busy", 64'(Busy), 64'd0);
    tick(1);

    // Abort in the FIX cycle beats the write.
    issue(3'd0, 32'd2, 32'd2);
    tick(32);
    Abort = 1'b1;
    @(negedge Clk);
    chk("fix_busy", 64'(Busy), 64'd1);
    tick(1);
    Abort = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (Done) done_cnt++;
    end
    chk("abort_fix_done", 64'(done_cnt), 64'd0);
    chk("abort_fix_lo", 64'(ReadDataLo), 64'h1234);
    tick(1);

    // Abort in IDLE discards MTHI.
    Abort = 1'b1;
    issue(3'd4, 32'hDEAD, 32'd0);
    Abort = 1'b0;
    @(negedge Clk);
    chk("abort_idle_hi", 64'(ReadDataHi), 64'd1);
    tick(1);

    // Reset kills an in-flight op.
    issue(3'd3, 32'd100, 32'd7);
    tick(5);
    Rst = 1'b1;
    tick(1);
    Rst = 1'b0;
    @(negedge Clk);
    chk("rst_mid_hi", 64'(ReadDataHi), 64'd0);
    chk("rst_mid_busy", 64'(Busy), 64'd0);
    tick(40);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
